imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, instruction words stored; power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc  input  16  processor byte address of the fetch.
REQ-006 SHALL have port instruction  output  DATA_W  fetched word, combinational from pc and state.
REQ-007 SHALL have port ld_start  input  1  request to (re)load the program.
REQ-008 SHALL have port ld_valid  input  1  loader word valid.
REQ-009 SHALL have port ld_data  input  DATA_W  loader word.
REQ-010 SHALL have port ld_last  input  1  qualifies ld_data as the final word.
REQ-011 SHALL have port ld_ready  output  1  controller accepts a word this cycle.
REQ-012 SHALL have port ld_done  output  1  one-cycle pulse when a load completes.
REQ-013 SHALL have port ld_count  output  5  words written in the current or last load.
REQ-014 SHALL have port cpu_en  output  1  processor may advance its PC; high only in RUN.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, LOAD, RUN, registered and one-hot or binary at implementer choice.
REQ-016 IDLE: cpu_en=0, ld_ready=0; ld_start=1 -> CLEAR next cycle.
REQ-017 CLEAR: one cycle; all DEPTH words zeroed, write pointer and ld_count set to 0, then -> LOAD.
REQ-018 LOAD: ld_ready=1 while pointer < DEPTH; each ld_valid&&ld_ready cycle writes ld_data to mem[pointer], pointer and ld_count increment.
REQ-019 LOAD exits to RUN the cycle after a write with ld_last=1 or the DEPTH-th write, whichever first; ld_done pulses high for exactly that transition cycle (first RUN cycle).
REQ-020 ld_valid with ld_ready=0 SHALL be ignored; no word dropped or duplicated when ld_valid is held across cycles.
REQ-021 ld_start in LOAD SHALL restart: -> CLEAR, discarding the partial load.
REQ-022 RUN: cpu_en=1; ld_start=1 -> CLEAR, cpu_en low from the next cycle.
REQ-023 In RUN, instruction SHALL be mem[pc[4:1]] when pc < 2*DEPTH, else all zeros; pc[0] ignored.
REQ-024 Outside RUN, instruction SHALL be all zeros (NOP) regardless of pc.
REQ-025 A word written in cycle N SHALL be fetchable from cycle N+1; no read-during-write in RUN is possible.
REQ-026 Words beyond the last loaded word SHALL read as zero.
REQ-027 ld_count SHALL saturate at DEPTH and hold its value in RUN and IDLE until the next CLEAR.

Reset
REQ-028 reset=1 on a rising edge SHALL force IDLE, all memory words to 0, pointer 0, ld_count 0, ld_ready 0, ld_done 0, cpu_en 0.
REQ-029 reset SHALL take priority over ld_start and ld_valid in the same cycle, including mid-LOAD.
REQ-030 After reset deassertion, the block SHALL stay in IDLE until ld_start.

Structure
REQ-031 FSM state encoding, DEPTH and the NOP word constant SHALL live in a shared package, imem_pkg.
REQ-032 Storage SHALL be one sub-module, imem_ram: DEPTH x DATA_W, sync write, async read, sync clear-all input.
REQ-033 No latches; all outputs except instruction SHALL be registered or decoded from registered state.

Verification
REQ-034 Reset, then pc=0x0000 with no load -> instruction=0x0000, cpu_en=0, ld_ready=0.
REQ-035 ld_start; send 0x8180, 0x2CB2, 0xDC67 (last on third) back-to-back -> ld_done pulses once, ld_count=3, cpu_en=1; pc=0x0002 gives 0x2CB2, pc=0x0006 gives 0x0000.
REQ-036 Load all 16 words with ld_last never asserted -> RUN after 16th write, ld_ready low after it; pc=0x001E returns word 15, pc=0x0020 returns 0x0000.
REQ-037 ld_valid toggled every other cycle with bubbles during LOAD -> exactly the valid words stored in order, ld_count matches.
REQ-038 In RUN, ld_start then 2 words -> cpu_en falls next cycle, old words 2..15 read 0 after reload, instruction=0 until new RUN.
REQ-039 reset asserted mid-LOAD after 5 words with ld_valid high -> IDLE, ld_count=0, memory zero, ld_done never pulses.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory load controller.
package imem_pkg;
  localparam int IMEM_DEPTH  = 16;
  localparam int IMEM_DATA_W = 16;
  // NOP is all zeros; sliced to DATA_W at the point of use
  localparam logic [63:0] IMEM_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } imem_state_t;
endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, synchronous clear-all.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // clear wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_load_ctrl.sv
// Program loader for a small instruction memory: clear, stream words in, then
// let the processor fetch until a reload is requested.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruction,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [4:0]        ld_count,
  output logic              cpu_en
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [16:0] PC_LIM  = 17'(2 * DEPTH);

  imem_state_t       state_q, state_d;
  logic [4:0]        ptr_q;
  logic              done_q;
  logic              wr_en;
  logic              ram_clr;
  logic [DATA_W-1:0] rd_data;

  assign ld_ready = (state_q == ST_LOAD) && (ptr_q < DEPTH_C);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE:  if (ld_start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_LOAD;
      ST_LOAD: begin
        // a restart discards the partial load, so no write this cycle
        if (ld_start) begin
          state_d = ST_CLEAR;
        end else if (ld_valid && ld_ready) begin
          wr_en = 1'b1;
          if (ld_last || ptr_q == DEPTH_C - 5'd1) state_d = ST_RUN;
        end
      end
      ST_RUN:   if (ld_start) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_LOAD) && (state_d == ST_RUN);
      if (state_q == ST_CLEAR) ptr_q <= '0;
      else if (wr_en)          ptr_q <= ptr_q + 5'd1;
    end
  end

  assign ram_clr = reset || (state_q == ST_CLEAR);

  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .clr   (ram_clr),
    .we    (wr_en),
    .waddr (ptr_q[AW-1:0]),
    .wdata (ld_data),
    .raddr (pc[AW:1]),
    .rdata (rd_data)
  );

  // byte address: pc[0] is dropped, anything past the array fetches NOP
  assign instruction = (state_q == ST_RUN && {1'b0, pc} < PC_LIM) ? rd_data
                                                                  : IMEM_NOP[DATA_W-1:0];
  assign ld_done  = done_q;
  assign ld_count = ptr_q;
  assign cpu_en   = (state_q == ST_RUN);
endmodule
